ram_access_arbiter: RTL and testbench

//  Shares the single-port 64-bit External_RAM between the instruction-fetch port and the load/store port.

---
 rtl/ram_access_arbiter_pkg.sv | 46 ++++
 rtl/ram_access_arbiter_align.sv | 48 ++++
 rtl/ram_access_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_ram_access_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_access_arbiter_pkg.sv
// Shared encodings for the RAM access arbiter: access sizes, arbiter states, grant owner.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package ram_access_arbiter_pkg;

  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;
  localparam logic [1:0] MEM_SIZE_D = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_FETCH = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_t;

  // Byte-lane mask of an access of the given size, anchored at lane 0.
  function automatic logic [7:0] size_lane_mask(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      MEM_SIZE_B: m = 8'h01;
      MEM_SIZE_H: m = 8'h03;
      MEM_SIZE_W: m = 8'h0F;
      default:    m = 8'hFF;
    endcase
    return m;
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] size_align_bits(input logic [1:0] size);
    logic [2:0] a;
    case (size)
      MEM_SIZE_B: a = 3'd0;
      MEM_SIZE_H: a = 3'd1;
      MEM_SIZE_W: a = 3'd3;
      default:    a = 3'd7;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/ram_access_arbiter_align.sv
// Byte-lane alignment: store mask/value placement, load extract+extend, misalign detect.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module ram_access_arbiter_align
  import ram_access_arbiter_pkg::*;
(
  input  logic [2:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [63:0] wdata,
  input  logic [63:0] rword,
  output logic [7:0]  mask,
  output logic [63:0] value,
  output logic [63:0] load_data,
  output logic        misaligned
);

  logic [5:0]  bit_shift;
  logic [63:0] wdata_trim;
  logic [63:0] shifted;

  // Place store data on its lanes and pull load data down from its lanes.
  always_comb begin
    bit_shift  = {offset, 3'b000};
    misaligned = (offset & size_align_bits(size)) != 3'd0;
    mask       = size_lane_mask(size) << offset;

    case (size)
      MEM_SIZE_B: wdata_trim = {56'b0, wdata[7:0]};
      MEM_SIZE_H: wdata_trim = {48'b0, wdata[15:0]};
      MEM_SIZE_W: wdata_trim = {32'b0, wdata[31:0]};
      default:    wdata_trim = wdata;
    endcase
    value = wdata_trim << bit_shift;

    shifted = rword >> bit_shift;
    case (size)
      MEM_SIZE_B: load_data = is_unsigned ? {56'b0, shifted[7:0]}
                                          : {{56{shifted[7]}}, shifted[7:0]};
      MEM_SIZE_H: load_data = is_unsigned ? {48'b0, shifted[15:0]}
                                          : {{48{shifted[15]}}, shifted[15:0]};
      MEM_SIZE_W: load_data = is_unsigned ? {32'b0, shifted[31:0]}
                                          : {{32{shifted[31]}}, shifted[31:0]};
      default:    load_data = shifted;
    endcase
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Round-robin share of one single-port 64-bit RAM between instruction fetch and load/store.
// Latency: req->ack 3 cycles (IDLE, ACCESS, DONE); 2 cycles for a misaligned data access.
// Backpressure: requesters hold req until their one-cycle ack; one access in flight at a time.
module ram_access_arbiter
  import ram_access_arbiter_pkg::*;
#(
  parameter int WORD_IDX_W = 10
)
(
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic                    ifetch_req_in,
  input  logic [WORD_IDX_W+2:0]   ifetch_addr_in,
  output logic                    ifetch_ack_out,
  output logic [31:0]             ifetch_data_out,
  input  logic                    dmem_req_in,
  input  logic                    dmem_we_in,
  input  logic [WORD_IDX_W+2:0]   dmem_addr_in,
  input  logic [1:0]              dmem_size_in,
  input  logic                    dmem_unsigned_in,
  input  logic [63:0]             dmem_wdata_in,
  output logic                    dmem_ack_out,
  output logic [63:0]             dmem_rdata_out,
  output logic                    dmem_err_out,
  output logic [WORD_IDX_W-1:0]   ram_address_out,
  output logic [63:0]             ram_value_out,
  output logic [7:0]              ram_mask_out,
  output logic                    ram_write_out,
  output logic                    ram_read_out,
  input  logic [63:0]             ram_data_in
);

  localparam int AW = WORD_IDX_W + 3;

  arb_state_t state, state_nxt;
  grant_t     last_grant, last_grant_nxt;

  // Request fields frozen at grant time; later input changes are ignored.
  logic          lat_fetch;
  logic          lat_we;
  logic          lat_unsigned;
  logic [1:0]    lat_size;
  logic [AW-1:0] lat_addr;

  logic take_data;
  logic take_fetch;

  logic [2:0]  al_offset;
  logic [1:0]  al_size;
  logic        al_unsigned;
  logic [7:0]  al_mask;
  logic [63:0] al_value;
  logic [63:0] al_load;
  logic        al_misaligned;

  logic                  ifetch_ack_nxt;
  logic [31:0]           ifetch_data_nxt;
  logic                  dmem_ack_nxt;
  logic [63:0]           dmem_rdata_nxt;
  logic                  dmem_err_nxt;
  logic [WORD_IDX_W-1:0] ram_address_nxt;
  logic [63:0]           ram_value_nxt;
  logic [7:0]            ram_mask_nxt;
  logic                  ram_write_nxt;
  logic                  ram_read_nxt;

  // Data wins when alone or when fetch had the previous grant.
  assign take_data  = dmem_req_in && (!ifetch_req_in || (last_grant == GRANT_FETCH));
  assign take_fetch = ifetch_req_in && !take_data;

  // In IDLE the aligner sees the live request (store placement, misalign);
  // afterwards it sees the latched request (load extraction at end of ACCESS).
  assign al_offset   = (state == ST_IDLE) ? dmem_addr_in[2:0] : lat_addr[2:0];
  assign al_size     = (state == ST_IDLE) ? dmem_size_in      : lat_size;
  assign al_unsigned = (state == ST_IDLE) ? dmem_unsigned_in  : lat_unsigned;

  ram_access_arbiter_align u_align (
    .offset      (al_offset),
    .size        (al_size),
    .is_unsigned (al_unsigned),
    .wdata       (dmem_wdata_in),
    .rword       (ram_data_in),
    .mask        (al_mask),
    .value       (al_value),
    .load_data   (al_load),
    .misaligned  (al_misaligned)
  );

  // State and round-robin pointer.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state      <= ST_IDLE;
      last_grant <= GRANT_FETCH;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Next state and next registered outputs; every output is 0 unless a state drives it.
  always_comb begin
    state_nxt       = state;
    last_grant_nxt  = last_grant;
    ifetch_ack_nxt  = 1'b0;
    ifetch_data_nxt = '0;
    dmem_ack_nxt    = 1'b0;
    dmem_rdata_nxt  = '0;
    dmem_err_nxt    = 1'b0;
    ram_address_nxt = '0;
    ram_value_nxt   = '0;
    ram_mask_nxt    = '0;
    ram_write_nxt   = 1'b0;
    ram_read_nxt    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (take_data) begin
          last_grant_nxt = GRANT_DATA;
          if (al_misaligned) begin
            state_nxt    = ST_DONE;
            dmem_ack_nxt = 1'b1;
            dmem_err_nxt = 1'b1;
          end else begin
            state_nxt       = ST_ACCESS;
            ram_address_nxt = dmem_addr_in[AW-1:3];
            if (dmem_we_in) begin
              ram_write_nxt = 1'b1;
              ram_mask_nxt  = al_mask;
              ram_value_nxt = al_value;
            end else begin
              ram_read_nxt = 1'b1;
            end
          end
        end else if (take_fetch) begin
          last_grant_nxt  = GRANT_FETCH;
          state_nxt       = ST_ACCESS;
          ram_address_nxt = ifetch_addr_in[AW-1:3];
          ram_read_nxt    = 1'b1;
        end
      end
      ST_ACCESS: begin
        state_nxt = ST_DONE;
        if (lat_fetch) begin
          ifetch_ack_nxt  = 1'b1;
          ifetch_data_nxt = lat_addr[2] ? ram_data_in[63:32] : ram_data_in[31:0];
        end else begin
          dmem_ack_nxt   = 1'b1;
          dmem_rdata_nxt = lat_we ? 64'b0 : al_load;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Latch the granted request's fields when leaving IDLE.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      lat_fetch    <= 1'b0;
      lat_we       <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_size     <= MEM_SIZE_B;
      lat_addr     <= '0;
    end else if ((state == ST_IDLE) && (take_data || take_fetch)) begin
      lat_fetch    <= take_fetch;
      lat_we       <= take_data && dmem_we_in;
      lat_unsigned <= dmem_unsigned_in;
      lat_size     <= dmem_size_in;
      lat_addr     <= take_fetch ? ifetch_addr_in : dmem_addr_in;
    end
  end

  // Output registers; reset drops an in-flight RAM strobe immediately.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      ifetch_ack_out  <= 1'b0;
      ifetch_data_out <= '0;
      dmem_ack_out    <= 1'b0;
      dmem_rdata_out  <= '0;
      dmem_err_out    <= 1'b0;
      ram_address_out <= '0;
      ram_value_out   <= '0;
      ram_mask_out    <= '0;
      ram_write_out   <= 1'b0;
      ram_read_out    <= 1'b0;
    end else begin
      ifetch_ack_out  <= ifetch_ack_nxt;
      ifetch_data_out <= ifetch_data_nxt;
      dmem_ack_out    <= dmem_ack_nxt;
      dmem_rdata_out  <= dmem_rdata_nxt;
      dmem_err_out    <= dmem_err_nxt;
      ram_address_out <= ram_address_nxt;
      ram_value_out   <= ram_value_nxt;
      ram_mask_out    <= ram_mask_nxt;
      ram_write_out   <= ram_write_nxt;
      ram_read_out    <= ram_read_nxt;
    end
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a behavioural negedge RAM.
// Latency: checks 3-cycle ack (2 on misalign) counting the request cycle as cycle 1.
// Backpressure: requests held until ack, dropped in the DONE cycle.
module tb_ram_access_arbiter;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        ifetch_req_in;
  logic [12:0] ifetch_addr_in;
  logic        ifetch_ack_out;
  logic [31:0] ifetch_data_out;
  logic        dmem_req_in;
  logic        dmem_we_in;
  logic [12:0] dmem_addr_in;
  logic [1:0]  dmem_size_in;
  logic        dmem_unsigned_in;
  logic [63:0] dmem_wdata_in;
  logic        dmem_ack_out;
  logic [63:0] dmem_rdata_out;
  logic        dmem_err_out;
  logic [9:0]  ram_address_out;
  logic [63:0] ram_value_out;
  logic [7:0]  ram_mask_out;
  logic        ram_write_out;
  logic        ram_read_out;
  logic [63:0] ram_data_in;

  int checks = 0;
  int errors = 0;

  ram_access_arbiter #(.WORD_IDX_W(10)) dut (
    .clk_in           (clk_in),
    .reset_in         (reset_in),
    .ifetch_req_in    (ifetch_req_in),
    .ifetch_addr_in   (ifetch_addr_in),
    .ifetch_ack_out   (ifetch_ack_out),
    .ifetch_data_out  (ifetch_data_out),
    .dmem_req_in      (dmem_req_in),
    .dmem_we_in       (dmem_we_in),
    .dmem_addr_in     (dmem_addr_in),
    .dmem_size_in     (dmem_size_in),
    .dmem_unsigned_in (dmem_unsigned_in),
    .dmem_wdata_in    (dmem_wdata_in),
    .dmem_ack_out     (dmem_ack_out),
    .dmem_rdata_out   (dmem_rdata_out),
    .dmem_err_out     (dmem_err_out),
    .ram_address_out  (ram_address_out),
    .ram_value_out    (ram_value_out),
    .ram_mask_out     (ram_mask_out),
    .ram_write_out    (ram_write_out),
    .ram_read_out     (ram_read_out),
    .ram_data_in      (ram_data_in)
  );

  always #5 clk_in = ~clk_in;

  // External RAM model: reads and masked writes happen on the falling edge.
  logic [63:0] mem [0:1023];
  always @(negedge clk_in) begin
    if (ram_read_out) ram_data_in <= mem[ram_address_out];
    if (ram_write_out)
      for (int b = 0; b < 8; b++)
        if (ram_mask_out[b]) mem[ram_address_out][8*b +: 8] <= ram_value_out[8*b +: 8];
  end

  typedef struct {
    string       name;
    logic        is_fetch;
    logic        we;
    logic [12:0] addr;
    logic [1:0]  size;      // 0=B 1=H 2=W 3=D
    logic        uns;
    logic [63:0] wdata;
    logic [63:0] exp_data;
    logic        exp_err;
    logic [7:0]  exp_mask;
    logic [63:0] exp_value;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input string name, input logic is_fetch, input logic we,
                              input logic [12:0] addr, input logic [1:0] size, input logic uns,
                              input logic [63:0] wdata, input logic [63:0] exp_data,
                              input logic exp_err, input logic [7:0] exp_mask,
                              input logic [63:0] exp_value);
    vec_t v;
    v.name = name; v.is_fetch = is_fetch; v.we = we; v.addr = addr; v.size = size;
    v.uns = uns; v.wdata = wdata; v.exp_data = exp_data; v.exp_err = exp_err;
    v.exp_mask = exp_mask; v.exp_value = exp_value;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic outs_nonzero();
    return |{ifetch_ack_out, ifetch_data_out, dmem_ack_out, dmem_rdata_out, dmem_err_out,
             ram_address_out, ram_value_out, ram_mask_out, ram_write_out, ram_read_out};
  endfunction

  // Issue one request from IDLE, watch the RAM side, and check the completion.
  task automatic run_vec(input vec_t v);
    int          cyc;
    int          ack_cyc;
    logic        got;
    logic        seen_strobe;
    logic        seen_write;
    logic        seen_other;
    logic [7:0]  s_mask;
    logic [63:0] s_value;
    logic [9:0]  s_addr;
    logic [63:0] act_data;
    logic        act_err;
    logic [12:0] a;
    cyc = 1; ack_cyc = 0; got = 0; seen_strobe = 0; seen_write = 0; seen_other = 0;
    s_mask = 0; s_value = 0; s_addr = 0; act_data = 0; act_err = 0;
    a = v.addr;
    if (v.is_fetch) begin
      ifetch_addr_in = v.addr; ifetch_req_in = 1'b1;
    end else begin
      dmem_we_in = v.we; dmem_addr_in = v.addr; dmem_size_in = v.size;
      dmem_unsigned_in = v.uns; dmem_wdata_in = v.wdata; dmem_req_in = 1'b1;
    end
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk_in); #1;
      cyc++;
      if (ram_read_out || ram_write_out) begin
        seen_strobe = 1; s_mask = ram_mask_out; s_value = ram_value_out; s_addr = ram_address_out;
      end
      if (ram_write_out) seen_write = 1;
      if (v.is_fetch ? (dmem_ack_out || dmem_err_out || dmem_rdata_out != 0)
                     : (ifetch_ack_out || ifetch_data_out != 0)) seen_other = 1;
      if (v.is_fetch ? ifetch_ack_out : dmem_ack_out) begin
        got = 1; ack_cyc = cyc;
        act_data = v.is_fetch ? {32'b0, ifetch_data_out} : dmem_rdata_out;
        act_err  = v.is_fetch ? 1'b0 : dmem_err_out;
      end
    end
    ifetch_req_in = 1'b0;
    dmem_req_in   = 1'b0;
    check({v.name, "/ack_cycle"}, 64'(ack_cyc), v.exp_err ? 64'd2 : 64'd3);
    check({v.name, "/data"}, act_data, v.exp_data);
    check({v.name, "/err"}, 64'(act_err), 64'(v.exp_err));
    check({v.name, "/strobe"}, 64'(seen_strobe), 64'(!v.exp_err));
    check({v.name, "/write"}, 64'(seen_write), 64'(!v.exp_err && v.we && !v.is_fetch));
    check({v.name, "/other_port_quiet"}, 64'(seen_other), 64'd0);
    if (!v.exp_err) begin
      check({v.name, "/ram_addr"}, 64'(s_addr), 64'(a[12:3]));
      check({v.name, "/mask"}, 64'(s_mask), 64'(v.exp_mask));
      if (v.we && !v.is_fetch) check({v.name, "/value"}, s_value, v.exp_value);
    end
    @(posedge clk_in); #1;
    check({v.name, "/ack_pulse_ends"}, 64'(ifetch_ack_out || dmem_ack_out), 64'd0);
  endtask

  initial begin
    int          n;
    int          cyc;
    logic [1:0]  exp_port [4];
    int          exp_cyc  [4];

    reset_in = 1'b1;
    ifetch_req_in = 0; ifetch_addr_in = 0;
    dmem_req_in = 0; dmem_we_in = 0; dmem_addr_in = 0; dmem_size_in = 0;
    dmem_unsigned_in = 0; dmem_wdata_in = 0;

    //            name        F  WE addr     sz U  wdata                  exp_data               err mask   exp_value
    vq.push_back(mk("sd_008",  0, 1, 13'h008, 3, 0, 64'h11223344_AABBCCDD, 64'h0,                 0, 8'hFF, 64'h11223344_AABBCCDD));
    vq.push_back(mk("if_008",  1, 0, 13'h008, 0, 0, 64'h0,                 64'hAABBCCDD,          0, 8'h00, 64'h0));
    vq.push_back(mk("if_00c",  1, 0, 13'h00C, 0, 0, 64'h0,                 64'h11223344,          0, 8'h00, 64'h0));
    vq.push_back(mk("sb_013",  0, 1, 13'h013, 0, 0, 64'hA5,                64'h0,                 0, 8'h08, 64'h00000000_A5000000));
    vq.push_back(mk("lb_013",  0, 0, 13'h013, 0, 0, 64'h0,                 64'hFFFFFFFF_FFFFFFA5, 0, 8'h00, 64'h0));
    vq.push_back(mk("lbu_013", 0, 0, 13'h013, 0, 1, 64'h0,                 64'h00000000_000000A5, 0, 8'h00, 64'h0));
    vq.push_back(mk("sw_006",  0, 1, 13'h006, 2, 0, 64'h12345678,          64'h0,                 1, 8'h00, 64'h0));
    vq.push_back(mk("sd_040",  0, 1, 13'h040, 3, 0, 64'hDEADBEEF_01234567, 64'h0,                 0, 8'hFF, 64'hDEADBEEF_01234567));
    vq.push_back(mk("ld_040",  0, 0, 13'h040, 3, 0, 64'h0,                 64'hDEADBEEF_01234567, 0, 8'h00, 64'h0));
    vq.push_back(mk("lh_044",  0, 0, 13'h044, 1, 0, 64'h0,                 64'hFFFFFFFF_FFFFBEEF, 0, 8'h00, 64'h0));
    vq.push_back(mk("lhu_046", 0, 0, 13'h046, 1, 1, 64'h0,                 64'h00000000_0000DEAD, 0, 8'h00, 64'h0));
    vq.push_back(mk("lw_044",  0, 0, 13'h044, 2, 0, 64'h0,                 64'hFFFFFFFF_DEADBEEF, 0, 8'h00, 64'h0));
    vq.push_back(mk("lwu_044", 0, 0, 13'h044, 2, 1, 64'h0,                 64'h00000000_DEADBEEF, 0, 8'h00, 64'h0));
    vq.push_back(mk("lw_040",  0, 0, 13'h040, 2, 0, 64'h0,                 64'h00000000_01234567, 0, 8'h00, 64'h0));
    vq.push_back(mk("sh_04a",  0, 1, 13'h04A, 1, 0, 64'h7788,              64'h0,                 0, 8'h0C, 64'h00000000_77880000));
    vq.push_back(mk("lh_04a",  0, 0, 13'h04A, 1, 0, 64'h0,                 64'h00000000_00007788, 0, 8'h00, 64'h0));
    vq.push_back(mk("lh_041",  0, 0, 13'h041, 1, 0, 64'h0,                 64'h0,                 1, 8'h00, 64'h0));
    vq.push_back(mk("ld_044",  0, 0, 13'h044, 3, 0, 64'h0,                 64'h0,                 1, 8'h00, 64'h0));
    vq.push_back(mk("lb_047",  0, 0, 13'h047, 0, 0, 64'h0,                 64'hFFFFFFFF_FFFFFFDE, 0, 8'h00, 64'h0));
    vq.push_back(mk("if_047",  1, 0, 13'h047, 0, 0, 64'h0,                 64'hDEADBEEF,          0, 8'h00, 64'h0));

    #2;
    check("reset_outputs_zero", 64'(outs_nonzero()), 64'd0);
    @(posedge clk_in); #1;
    reset_in = 1'b0;
    check("post_reset_idle_quiet", 64'(outs_nonzero()), 64'd0);

    foreach (vq[k]) run_vec(vq[k]);

    // Both ports requesting continuously: data first after reset, then alternate.
    reset_in = 1'b1;
    @(posedge clk_in); #1;
    reset_in = 1'b0;
    exp_port = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_cyc  = '{3, 6, 9, 12};
    ifetch_addr_in = 13'h008;
    dmem_we_in = 0; dmem_addr_in = 13'h040; dmem_size_in = 2'd3; dmem_unsigned_in = 0;
    ifetch_req_in = 1; dmem_req_in = 1;
    n = 0; cyc = 1;
    for (int i = 0; i < 20 && n < 4; i++) begin
      @(posedge clk_in); #1;
      cyc++;
      if (dmem_ack_out || ifetch_ack_out) begin
        check($sformatf("rr%0d_port", n), 64'({ifetch_ack_out, dmem_ack_out}), 64'(exp_port[n]));
        check($sformatf("rr%0d_cycle", n), 64'(cyc), 64'(exp_cyc[n]));
        if (ifetch_ack_out) check($sformatf("rr%0d_fetch_data", n), 64'(ifetch_data_out), 64'hAABBCCDD);
        else                check($sformatf("rr%0d_load_data", n), dmem_rdata_out, 64'hDEADBEEF_01234567);
        n++;
      end
    end
    check("rr_ack_count", 64'(n), 64'd4);
    ifetch_req_in = 0; dmem_req_in = 0;
    repeat (3) @(posedge clk_in);
    #1;

    // Reset asserted in the middle of a store's ACCESS cycle.
    dmem_we_in = 1; dmem_addr_in = 13'h080; dmem_size_in = 2'd3;
    dmem_wdata_in = 64'h0BAD_0BAD_0BAD_0BAD; dmem_req_in = 1;
    @(posedge clk_in); #1;
    check("rst_mid_write_active", 64'(ram_write_out), 64'd1);
    #2;
    reset_in = 1'b1;
    dmem_req_in = 0;
    #1;
    check("rst_mid_outputs_zero", 64'(outs_nonzero()), 64'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_in); #1;
      check($sformatf("rst_hold_no_ack%0d", i), 64'(dmem_ack_out || ifetch_ack_out), 64'd0);
    end
    reset_in = 1'b0;
    run_vec(mk("after_rst_ld_040", 0, 0, 13'h040, 3, 0, 64'h0, 64'hDEADBEEF_01234567, 0, 8'h00, 64'h0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
